// File: rtl/ripple_count_tracker_pkg.sv
// ripple_count_tracker_pkg
//   Shared defaults and FSM encoding for the ripple counter tracker.
//   CNT_W_DEF      : width of the raw ripple counter input
//   EXT_W_DEF      : width of the wrap-extension counter
//   STABLE_CYC_DEF : identical synchronized samples needed before accept (1..7)
package ripple_count_tracker_pkg;

    localparam int CNT_W_DEF      = 4;
    localparam int EXT_W_DEF      = 8;
    localparam int STABLE_CYC_DEF = 2;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } track_state_e;

endpackage

// File: rtl/ripple_count_tracker_sync_stable_filter.sv
// sync_stable_filter
//   Two-flop synchronizer followed by a stability filter. A value is
//   accepted once it has been seen STABLE_CYC consecutive times at the
//   synchronizer output.
//   clk    : system clock
//   clear  : synchronous active-high reset
//   cnt_in : raw asynchronous ripple counter value
//   accept : high while cand is a filtered, stable value
//   cand   : current candidate value
module sync_stable_filter
    import ripple_count_tracker_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int STABLE_CYC = STABLE_CYC_DEF
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [CNT_W-1:0] cnt_in,
    output logic             accept,
    output logic [CNT_W-1:0] cand
);

    localparam logic [2:0] STABLE_RUN = 3'(STABLE_CYC);

    logic [CNT_W-1:0] sync1_q, sync2_q;
    logic [CNT_W-1:0] cand_q, cand_d;
    logic [2:0]       run_q, run_d;

    always_comb begin
        cand_d = cand_q;
        run_d  = run_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            run_d  = 3'd1;
        end else if (run_q < STABLE_RUN) begin
            run_d = run_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            run_q   <= '0;
        end else begin
            sync1_q <= cnt_in;
            sync2_q <= sync1_q;
            cand_q  <= cand_d;
            run_q   <= run_d;
        end
    end

    // Also require the synchronizer to still agree with cand: this keeps the
    // reset-zero candidate from being accepted when the flushed synchronizer
    // is already carrying a different value in behind it.
    assign accept = (run_q == STABLE_RUN) && (sync2_q == cand_q);
    assign cand   = cand_q;

endmodule

// File: rtl/ripple_count_tracker.sv
// ripple_count_tracker
//   Brings a 4-bit asynchronous ripple counter into the clk domain, filters
//   glitches, extends it with a wrap counter and presents every new extended
//   value on a valid/ready output register.
//   clk        : system clock
//   clear      : synchronous active-high reset, highest priority
//   cnt_in     : raw ripple counter output (asynchronous, may glitch)
//   out_ready  : downstream accepts out_count when high with out_valid
//   out_valid  : out_count holds an unconsumed value
//   out_count  : extended count {ext, low}
//   wrap_pulse : one-cycle pulse on each accepted wrap
//   overflow   : sticky, ext wrapped past its maximum
//   dropped    : sticky, an unconsumed output was overwritten
module ripple_count_tracker
    import ripple_count_tracker_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int EXT_W      = EXT_W_DEF,
    parameter int STABLE_CYC = STABLE_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic [CNT_W-1:0]       cnt_in,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [CNT_W+EXT_W-1:0] out_count,
    output logic                   wrap_pulse,
    output logic                   overflow,
    output logic                   dropped
);

    logic             accept;
    logic [CNT_W-1:0] cand;

    sync_stable_filter #(
        .CNT_W      (CNT_W),
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clk    (clk),
        .clear  (clear),
        .cnt_in (cnt_in),
        .accept (accept),
        .cand   (cand)
    );

    track_state_e           state_q, state_d;
    logic [CNT_W-1:0]       prev_q, prev_d;
    logic [EXT_W-1:0]       ext_q, ext_d;
    logic                   out_valid_q, out_valid_d;
    logic [CNT_W+EXT_W-1:0] out_count_q, out_count_d;
    logic                   wrap_pulse_q, wrap_pulse_d;
    logic                   overflow_q, overflow_d;
    logic                   dropped_q, dropped_d;
    logic                   load;

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        ext_d        = ext_q;
        overflow_d   = overflow_q;
        wrap_pulse_d = 1'b0;
        load         = 1'b0;

        if (accept) begin
            if (state_q == ST_INIT) begin
                prev_d  = cand;
                load    = 1'b1;
                state_d = ST_TRACK;
            end else if (cand != prev_q) begin
                prev_d = cand;
                load   = 1'b1;
                // Up-count only: a smaller value means we passed 15 -> 0.
                if (cand < prev_q) begin
                    wrap_pulse_d = 1'b1;
                    ext_d        = ext_q + 1'b1;
                    if (ext_q == {EXT_W{1'b1}}) begin
                        overflow_d = 1'b1;
                    end
                end
            end
        end

        out_count_d = load ? {ext_d, cand} : out_count_q;

        if (load) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // Overwrite without a same-edge transfer loses the old value.
        dropped_d = dropped_q | (load & out_valid_q & ~out_ready);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q      <= ST_INIT;
            prev_q       <= '0;
            ext_q        <= '0;
            out_valid_q  <= 1'b0;
            out_count_q  <= '0;
            wrap_pulse_q <= 1'b0;
            overflow_q   <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            ext_q        <= ext_d;
            out_valid_q  <= out_valid_d;
            out_count_q  <= out_count_d;
            wrap_pulse_q <= wrap_pulse_d;
            overflow_q   <= overflow_d;
            dropped_q    <= dropped_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_count  = out_count_q;
    assign wrap_pulse = wrap_pulse_q;
    assign overflow   = overflow_q;
    assign dropped    = dropped_q;

endmodule

// File: doc/ripple_count_tracker.md
Name: ripple_count_tracker

Overview:
- Downstream consumer of the 4-bit asynchronous ripple counter. Brings its output into the system clock domain and filters ripple glitches.
- Extends the count with an upper counter that increments on every 15→0 wrap.
- Presents each new extended value on a valid/ready output register.
- Turns a free-running, glitch-prone event counter into a clean, wide, handshaked count for downstream logic.

Parameters:
- CNT_W, 4, width of the ripple counter input.
- EXT_W, 8, width of the wrap-extension counter.
- STABLE_CYC, 2, consecutive identical synchronized samples required before a value is accepted (legal range 1..7).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clear  input  1  synchronous, active-high reset.
- cnt_in  input  CNT_W  raw ripple counter output; asynchronous to clk, may glitch.
- out_ready  input  1  downstream accepts out_count when high with out_valid.
- out_valid  output  1  out_count holds an unconsumed value.
- out_count  output  CNT_W+EXT_W  extended count {ext, low}.
- wrap_pulse  output  1  one-cycle pulse on each accepted wrap.
- overflow  output  1  sticky; ext wrapped past its maximum.
- dropped  output  1  sticky; an unconsumed output was overwritten.

Behaviour:
- Reset (clear=1 at an edge):
  - sync1, sync2, cand, run, prev and ext all go to 0.
  - FSM goes to INIT.
  - out_valid, out_count, wrap_pulse, overflow and dropped all go to 0.
  - clear has priority over every other event.
- Synchronizer: two flops, sync1<=cnt_in, sync2<=sync1.
- Stability filter, evaluated each cycle:
  - If sync2 != cand: cand<=sync2, run<=1.
  - Else if run<STABLE_CYC: run<=run+1.
  - The value is accepted in the cycle where run==STABLE_CYC.
- FSM:
  - INIT: on first accept, prev<=cand, ext stays 0, out_count<={0,cand}, out_valid<=1, go to TRACK. wrap_pulse does not fire.
  - TRACK: on accept with cand!=prev, prev<=cand.
    - If cand<prev (unsigned), it is a wrap: ext<=ext+1 and wrap_pulse=1 for that one cycle.
    - Load out_count with {new ext, cand} and set out_valid<=1.
  - TRACK: cand==prev produces no action.
- Missed steps: upstream is up-count only. Any jump of fewer than 2^CNT_W steps is tracked correctly. A full-cycle or larger loss is undetectable and out of scope.
- Overflow: ext==all-ones and a wrap occurs → ext<=0, overflow<=1. overflow stays high until clear.
- Latency: cnt_in stable from before edge 1 → out_count/out_valid updated after edge 3+STABLE_CYC (edge 5 by default).
- Handshake:
  - A transfer occurs when out_valid && out_ready at an edge; out_valid then falls unless a new load happens in the same edge.
  - A new load with out_valid=1 and out_ready=0 overwrites out_count, keeps out_valid=1 and sets dropped<=1 (sticky).
  - Simultaneous transfer and load: the new value is loaded, out_valid stays 1, dropped is not set.
  - out_count is stable while out_valid=1 and there is no new load.
- A glitch shorter than STABLE_CYC cycles at sync2 is never accepted.
- clear mid-operation discards any pending output without a handshake.

Decomposition:
- Shared package/header holds:
  - CNT_W, EXT_W and STABLE_CYC defaults.
  - FSM state encoding: INIT=1'b0, TRACK=1'b1.
- One sub-module, sync_stable_filter, contains the two-flop synchronizer, cand/run logic and the accept strobe. It outputs accept and cand.
- Wrap, extension, FSM and output register live in the top module.

Test Plan:
- Reset, then cnt_in held at 4'd3 → first output {8'd0,4'd3} at edge 5 after the change; wrap_pulse stays 0.
- cnt_in steps 0..15 then 0 at 10 clk/step with out_ready=1 → sixteen outputs 0..15, then out_count=12'h010 with one wrap_pulse cycle.
- cnt_in=5, one-cycle glitch to 7, back to 5 → no output for 7 and no change from 5.
- ext preset near max (256 wraps, or EXT_W=1 build) → overflow goes to 1 on the 2^EXT_W-th wrap; out_count high bits return to 0; overflow stays 1 until clear.
- out_ready=0 across two accepted updates (2, then 3) → out_count=3, out_valid=1, dropped=1. Then out_ready=1 → one transfer, out_valid falls.
- clear asserted while out_valid=1 and cnt_in=9 → all outputs 0 next edge. After release, first output is {0,9} from INIT with no wrap.
